// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button conditioner.
// Holds the per-channel FSM state enum, 100 MHz defaults and a counter-width helper.
package btn_pkg;

  typedef enum logic [1:0] {
    BTN_IDLE,
    BTN_WAIT_PRESS,
    BTN_PRESSED,
    BTN_WAIT_RELEASE
  } btnState_e;

  // Defaults for a 100 MHz ClkPort
  localparam int BTN_NUM_DEF          = 5;
  localparam int BTN_DEBOUNCE_DEF     = 1_000_000;
  localparam int BTN_REPEAT_DELAY_DEF = 50_000_000;
  localparam int BTN_REPEAT_RATE_DEF  = 10_000_000;

  // Bits needed to count 0 .. max(a,b,c)-1
  function automatic int btnCntWidth(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/btn_if.sv
// Button bundle between the board pins / game logic and the conditioner.
// master: drives btn_raw, consumes level/press/release. slave: the conditioner.
interface btn_if #(
  parameter int NUM_BTNS = 5
);

  logic [NUM_BTNS-1:0] btn_raw;
  logic [NUM_BTNS-1:0] btn_level;
  logic [NUM_BTNS-1:0] btn_press;
  logic [NUM_BTNS-1:0] btn_release;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release
  );

endinterface

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, optional inversion, debounce FSM.
// Ports: clk, rst (async high), rawIn; registered level, press and relPulse.
// Auto-repeat of press pulses is built only when BTN_AUTOREPEAT_EN is defined.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES     = BTN_DEBOUNCE_DEF,
  parameter int   REPEAT_DELAY_CYCLES = BTN_REPEAT_DELAY_DEF,
  parameter int   REPEAT_RATE_CYCLES  = BTN_REPEAT_RATE_DEF,
  parameter logic INVERT              = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic rawIn,
  output logic level,
  output logic press,
  output logic relPulse
);

  localparam int CW = btnCntWidth(DEBOUNCE_CYCLES,
                                  REPEAT_DELAY_CYCLES,
                                  REPEAT_RATE_CYCLES);

  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Flops reset to the inactive pin level so sIn is 0 after reset
  logic syncA;
  logic syncB;
  logic sIn;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      syncA <= INVERT;
      syncB <= INVERT;
    end else begin
      syncA <= rawIn;
      syncB <= syncA;
    end
  end

  assign sIn = syncB ^ INVERT;

  btnState_e     state;
  logic [CW-1:0] cnt;

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [CW-1:0] RR_LAST = CW'(REPEAT_RATE_CYCLES - 1);

  logic [CW-1:0] rpt;
  logic          rptRate;
  logic [CW-1:0] rptLast;

  // First repeat waits the long delay, later ones the short rate
  assign rptLast = rptRate ? RR_LAST : RD_LAST;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= BTN_IDLE;
      cnt      <= '0;
      level    <= 1'b0;
      press    <= 1'b0;
      relPulse <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rpt      <= '0;
      rptRate  <= 1'b0;
`endif
    end else begin
      press    <= 1'b0;
      relPulse <= 1'b0;
      unique case (state)
        BTN_IDLE: begin
          if (sIn) begin
            state <= BTN_WAIT_PRESS;
            cnt   <= '0;
          end
        end
        BTN_WAIT_PRESS: begin
          if (!sIn) begin
            state <= BTN_IDLE;
          end else if (cnt == DB_LAST) begin
            state <= BTN_PRESSED;
            level <= 1'b1;
            press <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
            rpt     <= '0;
            rptRate <= 1'b0;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BTN_PRESSED: begin
          if (!sIn) begin
            // Repeat counter is left frozen until we come back
            state <= BTN_WAIT_RELEASE;
            cnt   <= '0;
          end
`ifdef BTN_AUTOREPEAT_EN
          else if (rpt == rptLast) begin
            press   <= 1'b1;
            rpt     <= '0;
            rptRate <= 1'b1;
          end else begin
            rpt <= rpt + 1'b1;
          end
`endif
        end
        BTN_WAIT_RELEASE: begin
          if (sIn) begin
            state <= BTN_PRESSED;
          end else if (cnt == DB_LAST) begin
            state    <= BTN_IDLE;
            level    <= 1'b0;
            relPulse <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= BTN_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Multi-channel push-button conditioner: sync, debounce, level + press/release pulses.
// Ports: ClkPort, Reset (async high), bus (btn_if.slave: btn_raw in; btn_level,
// btn_press, btn_release out). Define BTN_AUTOREPEAT_EN for held-button repeats.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int                NUM_BTNS            = BTN_NUM_DEF,
  parameter int                DEBOUNCE_CYCLES     = BTN_DEBOUNCE_DEF,
  parameter logic [NUM_BTNS-1:0] INVERT_MASK       = '0,
  parameter int                REPEAT_DELAY_CYCLES = BTN_REPEAT_DELAY_DEF,
  parameter int                REPEAT_RATE_CYCLES  = BTN_REPEAT_RATE_DEF
) (
  input logic ClkPort,
  input logic Reset,
  btn_if.slave bus
);

  logic [NUM_BTNS-1:0] lvl;
  logic [NUM_BTNS-1:0] prs;
  logic [NUM_BTNS-1:0] rel;

  for (genvar i = 0; i < NUM_BTNS; i++) begin : gCh
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES),
      .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
      .REPEAT_RATE_CYCLES (REPEAT_RATE_CYCLES),
      .INVERT             (INVERT_MASK[i])
    ) uCh (
      .clk     (ClkPort),
      .rst     (Reset),
      .rawIn   (bus.btn_raw[i]),
      .level   (lvl[i]),
      .press   (prs[i]),
      .relPulse(rel[i])
    );
  end

  assign bus.btn_level   = lvl;
  assign bus.btn_press   = prs;
  assign bus.btn_release = rel;

endmodule

// File: tb/tb_btn_conditioner.sv
// Randomised + directed bench for btn_conditioner against a run-length model.
// Model: a change is accepted once the synchronised input differs from the level for D+1 edges.
module tb_btn_conditioner;

  localparam int N  = 5;
  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RR = 5;
  localparam logic [N-1:0] INV = 5'b00100;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  btn_if #(.NUM_BTNS(N)) bus ();

  btn_conditioner #(
    .NUM_BTNS           (N),
    .DEBOUNCE_CYCLES    (DB),
    .INVERT_MASK        (INV),
    .REPEAT_DELAY_CYCLES(RD),
    .REPEAT_RATE_CYCLES (RR)
  ) dut (
    .ClkPort(clk),
    .Reset  (rst),
    .bus    (bus)
  );

  int nChecks = 0;
  int nFails  = 0;
  int cyc     = 0;

  // Model state
  logic [N-1:0] rawD1;
  logic [N-1:0] rawD2;
  logic [N-1:0] expLvl;
  logic [N-1:0] expPrs;
  logic [N-1:0] expRel;
  int           run [N];
  int           hold[N];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic modelReset();
    rawD1  = INV;
    rawD2  = INV;
    expLvl = '0;
    expPrs = '0;
    expRel = '0;
    for (int i = 0; i < N; i++) begin
      run[i]  = 0;
      hold[i] = 0;
    end
  endtask

  task automatic modelStep(input logic [N-1:0] r);
    logic s;
    expPrs = '0;
    expRel = '0;
    for (int i = 0; i < N; i++) begin
      s = rawD2[i] ^ INV[i];
      if (s != expLvl[i]) begin
        run[i]++;
        if (run[i] == DB + 1) begin
          run[i]    = 0;
          expLvl[i] = s;
          if (s) begin
            expPrs[i] = 1'b1;
            hold[i]   = 0;
          end else begin
            expRel[i] = 1'b1;
          end
        end
      end else begin
        // Steady pressed edge: counts toward auto-repeat
        if (expLvl[i] && run[i] == 0) begin
          hold[i]++;
`ifdef BTN_AUTOREPEAT_EN
          if (hold[i] >= RD && (hold[i] - RD) % RR == 0)
            expPrs[i] = 1'b1;
`endif
        end
        run[i] = 0;
      end
    end
    rawD2 = rawD1;
    rawD1 = r;
  endtask

  task automatic cycle(input logic [N-1:0] r, input logic rv);
    @(negedge clk);
    bus.btn_raw = r;
    rst = rv;
    if (rv) modelReset();
    @(posedge clk);
    if (rv) modelReset();
    else modelStep(r);
    cyc++;
    #1;
    check("level", bus.btn_level, expLvl);
    check("press", bus.btn_press, expPrs);
    check("release", bus.btn_release, expRel);
  endtask

  task automatic resetPhase(input logic [N-1:0] r, input int n);
    for (int i = 0; i < n; i++) begin
      cycle(r, 1'b1);
      check("rstOut", {bus.btn_level, bus.btn_press, bus.btn_release}, '0);
    end
    cyc = 0;
  endtask

  int cnt0, cnt4, cnt2, same;
  int remain[N];
  logic [N-1:0] cur;
  int rstLeft;
  logic rv;
  logic [N-1:0] r;
  logic expBit;

  initial begin
    rst = 1'b1;
    bus.btn_raw = INV;
    modelReset();

    // Clean press on ch0 at edge 10
    resetPhase(INV, 3);
    for (int e = 1; e <= 30; e++) begin
      cycle((e >= 10) ? (INV | 5'b00001) : INV, 1'b0);
      if (e == 16) check("cleanPressHi", bus.btn_press[0], 1);
      if (e == 15 || e == 17) check("cleanPressLo", bus.btn_press[0], 0);
      if (e == 30) check("cleanLevel", bus.btn_level[0], 1);
    end

    // Bounce on ch1
    resetPhase(INV, 2);
    for (int e = 1; e <= 20; e++) begin
      r = INV;
      if (e == 1 || e == 3) r[1] = 1'b1;
      cycle(r, 1'b0);
      check("bounce", {bus.btn_level[1], bus.btn_press[1],
                       bus.btn_release[1]}, 0);
    end

    // Release glitch on active-low ch2
    for (int e = 1; e <= 12; e++) cycle(5'b00000, 1'b0);
    check("glitchPre", bus.btn_level[2], 1);
    for (int e = 1; e <= 17; e++) begin
      cycle((e <= 2) ? 5'b00100 : 5'b00000, 1'b0);
      check("glitchLvl", bus.btn_level[2], 1);
      check("glitchRel", bus.btn_release[2], 0);
    end
    for (int e = 1; e <= 10; e++) cycle(INV, 1'b0);
    check("ch2Released", bus.btn_level[2], 0);

    // Simultaneous ch0/ch4, ch2 held inactive across reset
    resetPhase(INV, 3);
    cnt0 = 0; cnt4 = 0; cnt2 = 0; same = 0;
    for (int e = 1; e <= 14; e++) begin
      cycle((e >= 2) ? (INV | 5'b10001) : INV, 1'b0);
      if (bus.btn_press[0]) cnt0++;
      if (bus.btn_press[4]) cnt4++;
      if (bus.btn_press[2] || bus.btn_release[2]) cnt2++;
      if (bus.btn_press[0] && bus.btn_press[4]) same++;
    end
    check("simCnt0", cnt0, 1);
    check("simCnt4", cnt4, 1);
    check("simSame", same, 1);
    check("simCh2", cnt2, 0);

    // Reset mid-debounce on ch3
    resetPhase(INV, 2);
    cycle(INV | 5'b01000, 1'b0);
    cycle(INV | 5'b01000, 1'b0);
    resetPhase(INV | 5'b01000, 3);
    for (int e = 1; e <= 12; e++) begin
      cycle(INV | 5'b01000, 1'b0);
      check("rstMidPress", bus.btn_press[3], (e == 7) ? 1 : 0);
    end

    // Hold ch0 for a long time: repeats only with auto-repeat built
    resetPhase(INV, 2);
    for (int e = 1; e <= 60; e++) begin
      cycle((e <= 44) ? (INV | 5'b00001) : INV, 1'b0);
`ifdef BTN_AUTOREPEAT_EN
      expBit = (e == 7 || e == 27 || e == 32 || e == 37 || e == 42);
`else
      expBit = (e == 7);
`endif
      check("holdPress", bus.btn_press[0], expBit);
    end

    // Random bouncing with occasional resets
    resetPhase(INV, 2);
    cur = INV;
    rstLeft = 0;
    for (int i = 0; i < N; i++) remain[i] = 0;
    for (int e = 0; e < 3000; e++) begin
      for (int i = 0; i < N; i++) begin
        if (remain[i] == 0) begin
          cur[i] = 1'($urandom_range(0, 1));
          remain[i] = ($urandom_range(0, 2) == 0) ?
                      int'($urandom_range(1, 3)) :
                      int'($urandom_range(4, 30));
        end
        remain[i]--;
      end
      if (rstLeft == 0 && $urandom_range(0, 399) == 0)
        rstLeft = int'($urandom_range(1, 3));
      rv = (rstLeft > 0);
      if (rstLeft > 0) rstLeft--;
      cycle(cur, rv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

endmodule
